conv3x3_stream: RTL and testbench

Parametrised single-clock 3x3 convolution stream engine, the next generation of the accelerator datapath. It takes signed weights and unsigned pixels on one AXI-Stream slave, keeps two line buffers of IMG_W pixels, and emits one sign-extended valid-region (no padding) result per completed window on an AXI-Stream master. Backpressure is supported. Its operating mode comes from the AXI-Lite control block.

---
 rtl/conv3x3_stream.sv | 208 ++++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - 3x3 valid-region convolution stream engine
//
// Loads nine signed weights, then convolves a stream of unsigned pixels
// (IMG_H rows of IMG_W pixels). It emits one result per completed window.
// Optional build macro: CONV3X3_RELU_EN clamps negative sums to zero.
//
// Ports:
//   aclk, areset    clock, asynchronous active-high reset
//   mode            00 idle, 01 weight load, 10 compute, 11 idle
//   s_axis_*        weight/pixel input stream (tdata, tvalid, tlast, tready)
//   m_axis_*        result output stream (tdata, tstrb, tvalid, tlast, tready)
//   wload_done      pulse while the ninth weight is being accepted
//   frame_done      pulse while the tlast result beat is being accepted
//   err_len         sticky frame-length error, cleared in idle mode
module conv3x3_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int OUT_W  = 32
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic [OUT_W-1:0]    m_axis_tdata,
  output logic [OUT_W/8-1:0]  m_axis_tstrb,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic                wload_done,
  output logic                frame_done,
  output logic                err_len
);

  localparam int PROD_W = 2 * DATA_W + 1;
  localparam int SUM_W  = 2 * DATA_W + 5;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_COMP = 2'b10;

  logic [1:0]               mode_q;
  logic [RW-1:0]            r;
  logic [CW-1:0]            c;
  logic [3:0]               widx;
  logic signed [DATA_W-1:0] w [9];
  logic [DATA_W-1:0]        lb1 [IMG_W];   // row r-1
  logic [DATA_W-1:0]        lb2 [IMG_W];   // row r-2
  logic [DATA_W-1:0]        win_a [3];     // window column c-2, rows r-2..r
  logic [DATA_W-1:0]        win_b [3];     // window column c-1, rows r-2..r
  logic                     out_valid;
  logic [OUT_W-1:0]         out_data;
  logic                     out_last;
  logic                     err_q;

  logic                     mode_chg;
  logic                     is_load;
  logic                     is_comp;
  logic                     is_idle;
  logic [RW-1:0]            r_e;
  logic [CW-1:0]            c_e;
  logic [3:0]               widx_e;
  logic                     accept;
  logic                     w_acc;
  logic                     p_acc;
  logic                     at_end;
  logic                     win_done;
  logic [DATA_W-1:0]        col_new [3];
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  sum_o;
  logic [OUT_W-1:0]         out_next;

  // A mode change restarts the counters. A beat accepted in the same cycle
  // as the change is therefore treated as position zero.
  assign mode_chg = (mode != mode_q);
  assign is_load  = (mode == MODE_LOAD);
  assign is_comp  = (mode == MODE_COMP);
  assign is_idle  = !is_load && !is_comp;
  assign r_e      = mode_chg ? '0 : r;
  assign c_e      = mode_chg ? '0 : c;
  assign widx_e   = mode_chg ? '0 : widx;

  assign s_axis_tready = is_load | (is_comp & (!out_valid | m_axis_tready));
  assign accept   = s_axis_tvalid & s_axis_tready;
  assign w_acc    = accept & is_load;
  assign p_acc    = accept & is_comp;
  assign at_end   = (r_e == R_LAST) && (c_e == C_LAST);
  assign win_done = p_acc && (r_e >= RW'(2)) && (c_e >= CW'(2));

  assign wload_done    = w_acc && (widx_e == 4'd8);
  assign frame_done    = out_valid & m_axis_tready & out_last;
  assign m_axis_tdata  = out_data;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tlast  = out_last;
  assign m_axis_tstrb  = '1;
  assign err_len       = err_q;

  // Window taps: columns c-2 and c-1 come from the shift register. Column c
  // is the incoming pixel stacked under the two line-buffer entries.
  always_comb begin
    logic [DATA_W-1:0]       tap;
    logic [PROD_W-1:0]       pext;
    logic [PROD_W-1:0]       wext;
    logic signed [PROD_W-1:0] prod;
    tap  = '0;
    pext = '0;
    wext = '0;
    prod = '0;
    col_new[0] = lb2[c_e];
    col_new[1] = lb1[c_e];
    col_new[2] = s_axis_tdata;
    sum = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (j == 0)
          tap = win_a[i];
        else if (j == 1)
          tap = win_b[i];
        else
          tap = col_new[i];
        pext = {{(PROD_W - DATA_W){1'b0}}, tap};
        wext = {{(PROD_W - DATA_W){w[3*i+j][DATA_W-1]}}, w[3*i+j]};
        prod = $signed(wext) * $signed(pext);
        sum  = sum + SUM_W'(prod);
      end
    end
`ifdef CONV3X3_RELU_EN
    sum_o = sum[SUM_W-1] ? '0 : sum;
`else
    sum_o = sum;
`endif
    out_next = OUT_W'(sum_o);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mode_q    <= '0;
      r         <= '0;
      c         <= '0;
      widx      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      err_q     <= 1'b0;
      for (int k = 0; k < 9; k++) w[k] <= '0;
      for (int k = 0; k < IMG_W; k++) begin
        lb1[k] <= '0;
        lb2[k] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        win_a[k] <= '0;
        win_b[k] <= '0;
      end
    end else begin
      mode_q <= mode;
      if (mode_chg) begin
        r    <= '0;
        c    <= '0;
        widx <= '0;
      end

      if (w_acc) begin
        w[widx_e] <= s_axis_tdata;
        if (s_axis_tlast || widx_e == 4'd8)
          widx <= '0;
        else
          widx <= widx_e + 4'd1;
      end

      if (p_acc) begin
        lb2[c_e] <= lb1[c_e];
        lb1[c_e] <= s_axis_tdata;
        win_a    <= win_b;
        win_b    <= col_new;
        // Final pixel wraps; an early tlast abandons the frame.
        if (at_end || s_axis_tlast) begin
          r <= '0;
          c <= '0;
        end else if (c_e == C_LAST) begin
          c <= '0;
          r <= r_e + RW'(1);
        end else begin
          c <= c_e + CW'(1);
        end
      end

      // Reload takes priority so an accept and a new result share a cycle.
      if (win_done) begin
        out_valid <= 1'b1;
        out_data  <= out_next;
        out_last  <= at_end;
      end else if (m_axis_tready) begin
        out_valid <= 1'b0;
      end

      if (is_idle)
        err_q <= 1'b0;
      else if (p_acc && (at_end != s_axis_tlast))
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb/tb_conv3x3_stream.sv - self-checking bench for conv3x3_stream
module tb_conv3x3_stream;

  localparam int DW = 8;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int OW = 32;
  localparam int NP = IW * IH;

  logic          aclk;
  logic          areset;
  logic [1:0]    mode;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [OW-1:0] m_axis_tdata;
  logic [OW/8-1:0] m_axis_tstrb;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          wload_done;
  logic          frame_done;
  logic          err_len;

  conv3x3_stream #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .OUT_W(OW)) dut (
    .aclk(aclk), .areset(areset), .mode(mode),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .wload_done(wload_done),
    .frame_done(frame_done), .err_len(err_len)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  int wts [9];
  int pix [NP];
  logic [31:0] exp_d [$];
  logic        exp_l [$];
  logic [31:0] got_d [$];
  logic        got_l [$];
  int fd_cnt = 0;
  int wd_cnt = 0;

  // Output beats and pulses are observed on the falling edge, so each entry
  // is a beat that is accepted at the following rising edge.
  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      got_d.push_back(m_axis_tdata);
      got_l.push_back(m_axis_tlast);
    end
    if (frame_done) fd_cnt++;
    if (wload_done) wd_cnt++;
  end

  function automatic logic [31:0] ref_y(int r, int c);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += wts[3*i+j] * pix[(r-2+i)*IW + (c-2+j)];
`ifdef CONV3X3_RELU_EN
    if (s < 0) s = 0;
`endif
    return 32'(s);
  endfunction

  function automatic void build_exp();
    exp_d.delete();
    exp_l.delete();
    for (int r = 2; r < IH; r++)
      for (int c = 2; c < IW; c++) begin
        exp_d.push_back(ref_y(r, c));
        exp_l.push_back(r == IH-1 && c == IW-1);
      end
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic l, input bit bp);
    int  n;
    bit  acc;
    n = 0;
    acc = 0;
    if (bp && $urandom_range(0, 3) == 0) begin
      s_axis_tvalid = 1'b0;
      @(posedge aclk); #1;
    end
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk); #1;
      if (bp) m_axis_tready = 1'($urandom_range(0, 1));
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=no_accept want=accept within 200 cycles");
    end
  endtask

  task automatic send_frame(input int last_pos, input bit bp);
    for (int i = 0; i < NP; i++) send_beat(8'(pix[i]), (i == last_pos), bp);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    m_axis_tready = 1'b1;
    repeat (8) @(posedge aclk);
    #1;
  endtask

  task automatic load_weights();
    int wd0;
    wd0 = wd_cnt;
    mode = 2'b01;
    for (int i = 0; i < 9; i++) begin
      send_beat(8'(wts[i]), (i == 8), 0);
      if (i == 7) begin
        total++;
        if (wd_cnt - wd0 != 0) begin
          bad++;
          $display("FAIL wload_early got=%0d want=0", wd_cnt - wd0);
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    total++;
    if (wd_cnt - wd0 != 1) begin
      bad++;
      $display("FAIL wload_done got=%0d want=1", wd_cnt - wd0);
    end
  endtask

  task automatic set_ones();
    for (int i = 0; i < 9; i++) wts[i] = 1;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < NP; i++) pix[i] = i;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge aclk);
    #1;
    total++;
    if ({m_axis_tvalid, m_axis_tlast, wload_done, frame_done, err_len, s_axis_tready} !== 6'b0
        || m_axis_tdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%b/%h want=000000/00000000",
               {m_axis_tvalid, m_axis_tlast, wload_done, frame_done, err_len, s_axis_tready},
               m_axis_tdata);
    end
    total++;
    if (m_axis_tstrb !== 4'hF) begin
      bad++;
      $display("FAIL reset_tstrb got=%h want=f", m_axis_tstrb);
    end
    mode = 2'b01;
    #1;
    total++;
    if (s_axis_tready !== 1'b1) begin
      bad++;
      $display("FAIL reset_tready_load got=%b want=1", s_axis_tready);
    end
    mode = 2'b10;
    #1;
    total++;
    if (s_axis_tready !== 1'b1) begin
      bad++;
      $display("FAIL reset_tready_comp got=%b want=1", s_axis_tready);
    end
    mode = 2'b00;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic test_ones();
    int base, fd0;
    set_ones();
    set_ramp();
    load_weights();
    build_exp();
    base = got_d.size();
    fd0  = fd_cnt;
    mode = 2'b10;
    send_frame(NP-1, 0);
    drain();
    total++;
    if (got_d.size() - base != exp_d.size()) begin
      bad++;
      $display("FAIL ones_count got=%0d want=%0d", got_d.size() - base, exp_d.size());
    end
    for (int k = 0; k < exp_d.size() && base + k < got_d.size(); k++) begin
      total++;
      if (got_d[base+k] !== exp_d[k] || got_l[base+k] !== exp_l[k]) begin
        bad++;
        $display("FAIL ones_out%0d got=%h/%b want=%h/%b", k, got_d[base+k], got_l[base+k], exp_d[k], exp_l[k]);
      end
    end
    total++;
    if (fd_cnt - fd0 != 1 || err_len !== 1'b0) begin
      bad++;
      $display("FAIL ones_frame_done got=%0d/%b want=1/0", fd_cnt - fd0, err_len);
    end
  endtask

  task automatic test_latency();
    int k;
    bit want_v;
    for (int i = 0; i < 9; i++) wts[i] = (i == 4) ? 1 : 0;
    set_ramp();
    load_weights();
    build_exp();
    mode = 2'b10;
    k = 0;
    for (int i = 0; i < NP; i++) begin
      send_beat(8'(pix[i]), (i == NP-1), 0);
      s_axis_tvalid = 1'b0;
      @(negedge aclk);
      want_v = (i / IW >= 2) && (i % IW >= 2);
      total++;
      if (m_axis_tvalid !== want_v) begin
        bad++;
        $display("FAIL latency_valid%0d got=%b want=%b", i, m_axis_tvalid, want_v);
      end else if (want_v) begin
        total++;
        if (m_axis_tdata !== exp_d[k] || m_axis_tlast !== exp_l[k]) begin
          bad++;
          $display("FAIL latency_data%0d got=%h/%b want=%h/%b", i, m_axis_tdata, m_axis_tlast, exp_d[k], exp_l[k]);
        end
        k++;
      end
      @(posedge aclk); #1;
    end
    s_axis_tlast = 1'b0;
  endtask

  task automatic test_stall();
    int base;
    set_ones();
    set_ramp();
    load_weights();
    build_exp();
    base = got_d.size();
    mode = 2'b10;
    for (int i = 0; i <= 10; i++) send_beat(8'(pix[i]), 1'b0, 0);
    m_axis_tready = 1'b0;
    s_axis_tdata  = 8'(pix[11]);
    for (int n = 0; n < 5; n++) begin
      @(negedge aclk);
      total++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d[0] || s_axis_tready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d got=%b/%h/%b want=1/%h/0", n, m_axis_tvalid, m_axis_tdata, s_axis_tready, exp_d[0]);
      end
      @(posedge aclk); #1;
    end
    m_axis_tready = 1'b1;
    for (int i = 11; i < NP; i++) send_beat(8'(pix[i]), (i == NP-1), 0);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    drain();
    total++;
    if (got_d.size() - base != exp_d.size()) begin
      bad++;
      $display("FAIL stall_count got=%0d want=%0d", got_d.size() - base, exp_d.size());
    end
    for (int k = 0; k < exp_d.size() && base + k < got_d.size(); k++) begin
      total++;
      if (got_d[base+k] !== exp_d[k] || got_l[base+k] !== exp_l[k]) begin
        bad++;
        $display("FAIL stall_out%0d got=%h/%b want=%h/%b", k, got_d[base+k], got_l[base+k], exp_d[k], exp_l[k]);
      end
    end
  endtask

  task automatic test_negative();
    int base;
    for (int i = 0; i < 9; i++) wts[i] = (i == 4) ? -1 : 0;
    set_ramp();
    load_weights();
    build_exp();
    base = got_d.size();
    mode = 2'b10;
    send_frame(NP-1, 0);
    drain();
    total++;
    if (got_d.size() - base != exp_d.size()) begin
      bad++;
      $display("FAIL neg_count got=%0d want=%0d", got_d.size() - base, exp_d.size());
    end
    for (int k = 0; k < exp_d.size() && base + k < got_d.size(); k++) begin
      total++;
      if (got_d[base+k] !== exp_d[k] || got_l[base+k] !== exp_l[k]) begin
        bad++;
        $display("FAIL neg_out%0d got=%h/%b want=%h/%b", k, got_d[base+k], got_l[base+k], exp_d[k], exp_l[k]);
      end
    end
  endtask

  task automatic test_err_len();
    int base;
    set_ones();
    set_ramp();
    load_weights();
    build_exp();
    base = got_d.size();
    mode = 2'b10;
    for (int i = 0; i <= 5; i++) send_beat(8'(pix[i]), (i == 5), 0);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    drain();
    total++;
    if (got_d.size() != base || err_len !== 1'b1) begin
      bad++;
      $display("FAIL err_early got=%0d/%b want=0/1", got_d.size() - base, err_len);
    end
    base = got_d.size();
    send_frame(NP-1, 0);
    drain();
    total++;
    if (got_d.size() - base != exp_d.size()) begin
      bad++;
      $display("FAIL err_next_count got=%0d want=%0d", got_d.size() - base, exp_d.size());
    end
    for (int k = 0; k < exp_d.size() && base + k < got_d.size(); k++) begin
      total++;
      if (got_d[base+k] !== exp_d[k] || got_l[base+k] !== exp_l[k]) begin
        bad++;
        $display("FAIL err_next_out%0d got=%h/%b want=%h/%b", k, got_d[base+k], got_l[base+k], exp_d[k], exp_l[k]);
      end
    end
    total++;
    if (err_len !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky got=%b want=1", err_len);
    end
    mode = 2'b00;
    @(posedge aclk); #1;
    total++;
    if (err_len !== 1'b0) begin
      bad++;
      $display("FAIL err_idle_clear got=%b want=0", err_len);
    end
    // Final pixel without tlast: results still complete, error flagged.
    base = got_d.size();
    mode = 2'b10;
    send_frame(-1, 0);
    drain();
    total++;
    if (got_d.size() - base != exp_d.size() || err_len !== 1'b1) begin
      bad++;
      $display("FAIL err_missing got=%0d/%b want=%0d/1", got_d.size() - base, err_len, exp_d.size());
    end else begin
      total++;
      if (got_d[base+3] !== exp_d[3] || got_l[base+3] !== 1'b1) begin
        bad++;
        $display("FAIL err_missing_last got=%h/%b want=%h/1", got_d[base+3], got_l[base+3], exp_d[3]);
      end
    end
    mode = 2'b00;
    @(posedge aclk); #1;
  endtask

  task automatic test_areset();
    int base;
    set_ones();
    set_ramp();
    load_weights();
    mode = 2'b10;
    for (int i = 0; i <= 10; i++) send_beat(8'(pix[i]), 1'b0, 0);
    s_axis_tvalid = 1'b0;
    areset = 1'b1;
    #1;
    total++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'h0 || m_axis_tlast !== 1'b0 || err_len !== 1'b0) begin
      bad++;
      $display("FAIL areset_clear got=%b/%h/%b/%b want=0/00000000/0/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast, err_len);
    end
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;
    // Weights were cleared, so a frame now yields zeros.
    for (int i = 0; i < 9; i++) wts[i] = 0;
    build_exp();
    base = got_d.size();
    send_frame(NP-1, 0);
    drain();
    total++;
    if (got_d.size() - base != exp_d.size()) begin
      bad++;
      $display("FAIL areset_zero_count got=%0d want=%0d", got_d.size() - base, exp_d.size());
    end
    for (int k = 0; k < exp_d.size() && base + k < got_d.size(); k++) begin
      total++;
      if (got_d[base+k] !== exp_d[k]) begin
        bad++;
        $display("FAIL areset_zero_out%0d got=%h want=%h", k, got_d[base+k], exp_d[k]);
      end
    end
    set_ones();
    load_weights();
    build_exp();
    base = got_d.size();
    mode = 2'b10;
    send_frame(NP-1, 0);
    drain();
    total++;
    if (got_d.size() - base != exp_d.size()) begin
      bad++;
      $display("FAIL areset_reload_count got=%0d want=%0d", got_d.size() - base, exp_d.size());
    end
    for (int k = 0; k < exp_d.size() && base + k < got_d.size(); k++) begin
      total++;
      if (got_d[base+k] !== exp_d[k] || got_l[base+k] !== exp_l[k]) begin
        bad++;
        $display("FAIL areset_reload_out%0d got=%h/%b want=%h/%b", k, got_d[base+k], got_l[base+k], exp_d[k], exp_l[k]);
      end
    end
  endtask

  task automatic test_random();
    int base;
    logic [7:0] b;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 9; i++) begin
        b = 8'($urandom);
        wts[i] = $signed(b);
      end
      for (int i = 0; i < NP; i++) pix[i] = $urandom_range(0, 255);
      load_weights();
      mode = 2'b10;
      if (it == 0) begin
        // Partial frame abandoned by a mode change.
        for (int i = 0; i < 7; i++) send_beat(8'($urandom), 1'b0, 0);
        s_axis_tvalid = 1'b0;
        drain();
        mode = 2'b00;
        @(posedge aclk); #1;
        mode = 2'b10;
      end
      build_exp();
      base = got_d.size();
      send_frame(NP-1, 1);
      drain();
      total++;
      if (got_d.size() - base != exp_d.size()) begin
        bad++;
        $display("FAIL rand%0d_count got=%0d want=%0d", it, got_d.size() - base, exp_d.size());
      end
      for (int k = 0; k < exp_d.size() && base + k < got_d.size(); k++) begin
        total++;
        if (got_d[base+k] !== exp_d[k] || got_l[base+k] !== exp_l[k]) begin
          bad++;
          $display("FAIL rand%0d_out%0d got=%h/%b want=%h/%b", it, k, got_d[base+k], got_l[base+k], exp_d[k], exp_l[k]);
        end
      end
    end
  endtask

  initial begin
    areset        = 1'b1;
    mode          = 2'b00;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    test_reset();
    test_ones();
    test_latency();
    test_stall();
    test_negative();
    test_err_len();
    test_areset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

endmodule
